// File: rtl/l2_rsp_out_packetizer_pkg.sv
// Shared constants, types and helpers for the L2 response-out packetizer.
// This includes the coherence message encodings, the NoC flit layout, the
// packetizer FSM states and the header/flit builder functions.
package l2_rsp_out_packetizer_pkg;

  localparam int FLIT_W         = 64;
  localparam int WORD_W         = 64;
  localparam int WORDS_PER_LINE = 2;
  localparam int TILE_ID_W      = 6;
  localparam int LLC_SEL_BITS   = 2;
  localparam int MIX_MSG_W      = 3;
  localparam int LINE_ADDR_W    = 32;
  localparam int WORD_IDX_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  // Flit preamble bit positions inside the NoC data bus.
  localparam int NOC_HEAD_BIT   = FLIT_W + 1;
  localparam int NOC_TAIL_BIT   = FLIT_W;
  localparam int NOC_DATA_W     = FLIT_W + 2;

  // Coherence response encodings.
  localparam logic [MIX_MSG_W-1:0] RSP_S       = 3'd0;
  localparam logic [MIX_MSG_W-1:0] RSP_ODATA   = 3'd1;
  localparam logic [MIX_MSG_W-1:0] RSP_INV_ACK = 3'd2;
  localparam logic [MIX_MSG_W-1:0] RSP_NACK    = 3'd3;
  localparam logic [MIX_MSG_W-1:0] RSP_RVK_O   = 3'd4;
  localparam logic [MIX_MSG_W-1:0] RSP_V       = 3'd5;
  localparam logic [MIX_MSG_W-1:0] RSP_O       = 3'd6;

  // Field order matches the bus: head at NOC_HEAD_BIT, tail at NOC_TAIL_BIT.
  typedef struct packed {
    logic              head;
    logic              tail;
    logic [FLIT_W-1:0] payload;
  } noc_flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } pkt_state_e;

  // Messages that carry line data after the address flit.
  function automatic logic rsp_has_data(input logic [MIX_MSG_W-1:0] coh_msg);
    logic has;
    case (coh_msg)
      RSP_S:     has = 1'b1;
      RSP_ODATA: has = 1'b1;
      RSP_V:     has = 1'b1;
      RSP_RVK_O: has = 1'b1;
      default:   has = 1'b0;
    endcase
    return has;
  endfunction

  // Header payload, MSB down: src_id, dst_id, coh_msg, word_mask, zero pad.
  function automatic logic [FLIT_W-1:0] hdr_payload(
    input logic [TILE_ID_W-1:0]      src_id,
    input logic [TILE_ID_W-1:0]      dst_id,
    input logic [MIX_MSG_W-1:0]      coh_msg,
    input logic [WORDS_PER_LINE-1:0] word_mask
  );
    logic [FLIT_W-1:0] p;
    p = '0;
    p[FLIT_W-1 -: TILE_ID_W]                            = src_id;
    p[FLIT_W-1-TILE_ID_W -: TILE_ID_W]                  = dst_id;
    p[FLIT_W-1-2*TILE_ID_W -: MIX_MSG_W]                = coh_msg;
    p[FLIT_W-1-2*TILE_ID_W-MIX_MSG_W -: WORDS_PER_LINE] = word_mask;
    return p;
  endfunction

  function automatic noc_flit_t make_flit(
    input logic              head,
    input logic              tail,
    input logic [FLIT_W-1:0] payload
  );
    noc_flit_t f;
    f.head    = head;
    f.tail    = tail;
    f.payload = payload;
    return f;
  endfunction

endpackage

// File: rtl/l2_rsp_out_packetizer_mask_next_word.sv
// Finds the lowest set mask bit above idx_i (or at idx_i when incl_i is set),
// and reports whether that bit is the last set bit of the mask.
// This block is shared with the request-out packetizer.
module l2_mask_next_word #(
  parameter int WORDS = 2,
  parameter int IDX_W = 1
) (
  input  logic [WORDS-1:0] mask_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             incl_i,
  output logic             found_o,
  output logic [IDX_W-1:0] nxt_idx_o,
  output logic             last_o
);

  // Scan downward so the lowest qualifying bit wins, then look above it.
  always_comb begin
    logic hit;
    found_o   = 1'b0;
    nxt_idx_o = '0;
    last_o    = 1'b1;
    hit       = 1'b0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      hit       = mask_i[i] & ((i > int'(idx_i)) | (incl_i & (i == int'(idx_i))));
      found_o   = found_o | hit;
      nxt_idx_o = hit ? IDX_W'(i) : nxt_idx_o;
    end
    for (int i = 0; i < WORDS; i++) begin
      last_o = last_o & ~(mask_i[i] & (i > int'(nxt_idx_o)));
    end
  end

endmodule

// File: rtl/l2_rsp_out_packetizer.sv
// L2 response-out packetizer. It accepts one response message and emits the
// following flits: a header flit, an address flit, then each masked-in data
// word. The flit outputs are registered. The ready signal is also raised
// during the tail handshake, so back-to-back packets have no bubble.
import l2_rsp_out_packetizer_pkg::*;

module l2_rsp_out_packetizer (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TILE_ID_W-1:0]              local_tile_id,
  input  logic                              l2_rsp_out_valid,
  output logic                              l2_rsp_out_ready,
  input  logic [MIX_MSG_W-1:0]              rsp_coh_msg,
  input  logic [TILE_ID_W-1:0]              rsp_req_id,
  input  logic                              rsp_to_req,
  input  logic [LINE_ADDR_W-1:0]            rsp_addr,
  input  logic [WORDS_PER_LINE*WORD_W-1:0]  rsp_line,
  input  logic [WORDS_PER_LINE-1:0]         rsp_word_mask,
  output logic                              noc_rsp_valid,
  input  logic                              noc_rsp_ready,
  output logic [NOC_DATA_W-1:0]             noc_rsp_data
);

  pkt_state_e                       state_q;
  logic                             valid_q;
  noc_flit_t                        data_q;
  logic [WORD_IDX_W-1:0]            idx_q;
  logic [LINE_ADDR_W-1:0]           addr_q;
  logic [WORDS_PER_LINE*WORD_W-1:0] line_q;
  logic [WORDS_PER_LINE-1:0]        mask_q;
  logic [MIX_MSG_W-1:0]             coh_q;

  logic                  accept_s;
  logic                  tail_hs_s;
  logic                  no_data_s;
  logic [TILE_ID_W-1:0]  dst_s;
  noc_flit_t             hdr_flit_s;
  noc_flit_t             addr_flit_s;
  logic                  first_found_s;
  logic [WORD_IDX_W-1:0] first_idx_s;
  logic                  first_last_s;
  logic                  next_found_s;
  logic [WORD_IDX_W-1:0] next_idx_s;
  logic                  next_last_s;
  logic [WORD_W-1:0]     first_word_s;
  logic [WORD_W-1:0]     next_word_s;

  // Lowest set bit of the latched mask: the first data word of the packet.
  l2_mask_next_word #(
    .WORDS (WORDS_PER_LINE),
    .IDX_W (WORD_IDX_W)
  ) u_first_word (
    .mask_i    (mask_q),
    .idx_i     ({WORD_IDX_W{1'b0}}),
    .incl_i    (1'b1),
    .found_o   (first_found_s),
    .nxt_idx_o (first_idx_s),
    .last_o    (first_last_s)
  );

  // Next set bit strictly above the word currently on the bus.
  l2_mask_next_word #(
    .WORDS (WORDS_PER_LINE),
    .IDX_W (WORD_IDX_W)
  ) u_next_word (
    .mask_i    (mask_q),
    .idx_i     (idx_q),
    .incl_i    (1'b0),
    .found_o   (next_found_s),
    .nxt_idx_o (next_idx_s),
    .last_o    (next_last_s)
  );

  assign tail_hs_s = valid_q & noc_rsp_ready & data_q.tail;
  assign l2_rsp_out_ready = rst & ((state_q == ST_IDLE) | tail_hs_s);
  assign accept_s  = l2_rsp_out_valid & l2_rsp_out_ready;

  // A packet carries data only for data-bearing messages with a non-empty mask.
  assign no_data_s = ~rsp_has_data(coh_q) | ~first_found_s;

  // Route either back to the requester or to the home LLC tile selected by address LSBs.
  assign dst_s = rsp_to_req ? rsp_req_id
                            : {{(TILE_ID_W-LLC_SEL_BITS){1'b0}}, rsp_addr[LLC_SEL_BITS-1:0]};

  assign hdr_flit_s  = make_flit(1'b1, 1'b0,
                                 hdr_payload(local_tile_id, dst_s, rsp_coh_msg, rsp_word_mask));
  assign addr_flit_s = make_flit(1'b0, no_data_s,
                                 {{(FLIT_W-LINE_ADDR_W){1'b0}}, addr_q});

  assign first_word_s = line_q[int'(first_idx_s)*WORD_W +: WORD_W];
  assign next_word_s  = line_q[int'(next_idx_s)*WORD_W +: WORD_W];

  assign noc_rsp_valid = valid_q;
  assign noc_rsp_data  = data_q;

  // Packetizer FSM with registered flit outputs; a new accept always wins and starts a header.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      mask_q  <= '0;
      coh_q   <= '0;
    end else if (accept_s) begin
      addr_q  <= rsp_addr;
      line_q  <= rsp_line;
      mask_q  <= rsp_word_mask;
      coh_q   <= rsp_coh_msg;
      idx_q   <= '0;
      state_q <= ST_HDR;
      valid_q <= 1'b1;
      data_q  <= hdr_flit_s;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
        end
        ST_HDR: begin
          if (noc_rsp_ready) begin
            data_q  <= addr_flit_s;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (noc_rsp_ready) begin
            if (no_data_s) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              data_q  <= '0;
            end else begin
              state_q <= ST_DATA;
              idx_q   <= first_idx_s;
              data_q  <= make_flit(1'b0, first_last_s, first_word_s);
            end
          end
        end
        ST_DATA: begin
          if (noc_rsp_ready) begin
            if (data_q.tail || !next_found_s) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              data_q  <= '0;
            end else begin
              idx_q   <= next_idx_s;
              data_q  <= make_flit(1'b0, next_last_s, next_word_s);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/l2_rsp_out_packetizer.md
Name: l2_rsp_out_packetizer

Overview:
Downstream of the L2 core's response-out port. Captures one l2_rsp_out message at a time and serialises it into NoC flits for the coherence-response plane: a header flit, an address flit, then only the words whose word_mask bit is set. It provides the ready/valid backpressure the core sees on l2_rsp_out_ready.

Parameters:
FLIT_W, 64, flit payload width excluding the head/tail preamble bits
WORD_W, 64, bits per word; must equal FLIT_W
WORDS_PER_LINE, 2, words per cache line
TILE_ID_W, 6, tile id width
LLC_SEL_BITS, 2, line-address LSBs that select the home LLC tile

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
local_tile_id  in  TILE_ID_W  this tile's id, sampled at message accept
l2_rsp_out_valid  in  1  core response valid
l2_rsp_out_ready  out  1  packetizer can accept a message
rsp_coh_msg  in  MIX_MSG_W  response type
rsp_req_id  in  TILE_ID_W  requester tile
rsp_to_req  in  1  1: send to requester; 0: send to home LLC
rsp_addr  in  LINE_ADDR_W  line address
rsp_line  in  WORDS_PER_LINE*WORD_W  line data
rsp_word_mask  in  WORDS_PER_LINE  valid words
noc_rsp_valid  out  1  flit valid
noc_rsp_ready  in  1  NoC accepts flit
noc_rsp_data  out  FLIT_W+2  bit FLIT_W+1 = head, bit FLIT_W = tail, low bits = payload

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - noc_rsp_valid = 0, noc_rsp_data = 0.
  - l2_rsp_out_ready = 1 once rst deasserts.
  - Reset mid-message drops the packet; no partial flits follow.
- States: IDLE, HDR, ADDR, DATA.
- IDLE:
  - ready = 1.
  - On valid&ready, latch all rsp_* fields and local_tile_id; go to HDR.
- HDR:
  - noc_rsp_valid = 1, head = 1.
  - Payload, MSB down: src_id, dst_id, coh_msg, word_mask; zero-padded.
  - dst_id = rsp_to_req ? rsp_req_id : zero-extended rsp_addr[LLC_SEL_BITS-1:0].
  - On handshake go to ADDR.
- ADDR:
  - Payload = zero-extended latched addr.
  - tail = 1 when no data is sent, i.e. rsp_has_data(coh_msg) == 0 or word_mask == 0. Data words are then suppressed.
  - On handshake: to DATA (word index = lowest set mask bit), else finish.
- DATA:
  - Payload = line[idx*WORD_W +: WORD_W].
  - tail = 1 when no higher mask bit is set.
  - On handshake: advance idx to the next set bit; skipped words cost no cycles. On tail, finish.
- Finish:
  - l2_rsp_out_ready is also asserted combinationally while a tail flit handshakes, so a new message can be latched in that same cycle and go straight to HDR. This gives zero bubble between packets.
- Latency:
  - Header is presented the cycle after accept.
  - Thereafter 1 flit/cycle with noc_rsp_ready held high.
  - Packet length = 2 + popcount(mask), data messages only.
- Output stability:
  - noc_rsp_valid/data are registered.
  - Held stable while valid & !ready. No retraction.
- Input handshake: valid without ready holds the core. Fields are sampled only at the handshake.
- rsp_has_data is a package function:
  - Returns 1 for RSP_S, RSP_Odata, RSP_V, RSP_RVK_O.
  - Returns 0 otherwise (e.g. RSP_INV_ACK).
- Flit counter: width clog2(WORDS_PER_LINE); never wraps within a packet.

Decomposition:
- Shared package (spandex_consts/spandex_types):
  - MIX_MSG_W, LINE_ADDR_W and the coh_msg encodings.
  - Flit field offsets: NOC_HEAD_BIT, NOC_TAIL_BIT.
  - noc_flit_t.
  - rsp_has_data function.
- One natural sub-module, l2_mask_next_word: combinational "next set bit above idx / last bit" finder, reusable by the request-out packetizer.

Test Plan:
- Inv ack: coh_msg=RSP_INV_ACK, to_req=1, req_id=5, local=3, addr=0x1234 → 2 flits. Header head=1, src=3, dst=5; then addr flit 0x1234 with tail=1. ready back the cycle of the tail handshake.
- Full line: coh_msg=RSP_S, mask=2'b11, line={0xB,0xA} → 4 flits: hdr, addr, 0xA, 0xB. Tail only on 0xB, at 1 flit/cycle.
- Sparse: coh_msg=RSP_V, mask=2'b10 → hdr, addr, 0xB(tail). Word 0 never sent.
- Home routing: to_req=0, addr=0x...7, LLC_SEL_BITS=2 → dst_id=3. Data message with mask=0 → tail on addr flit.
- Backpressure: hold noc_rsp_ready=0 for 5 cycles on the data flit → data/valid constant. Second message queued behind it is accepted in the tail-handshake cycle, and its header follows with no bubble.
- Reset: assert rst low during DATA → valid=0 immediately. After release, IDLE with ready=1 and no stray flits.
